// File: rtl/gpio_pkg.sv
// Shared register map, bus width and edge-select encodings for the GPIO controller.
package gpio_pkg;

  localparam int BUS_W = 32;

  localparam logic [2:0] GPIO_IN       = 3'd0;
  localparam logic [2:0] GPIO_OUT      = 3'd1;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd2;
  localparam logic [2:0] GPIO_IRQ_PEND = 3'd3;
  localparam logic [2:0] GPIO_EDGE_CFG = 3'd4;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd5;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd6;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit 2-FF synchronizer followed by a stability debouncer.
// GPIO_DEBOUNCE_EN undefined: the debouncer collapses to one register after the synchronizer.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db
);

  logic sync_p0, sync_p1;

  // stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // stage p2: accept a change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync_p1 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db  <= sync_p1;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // stage p2: plain register after the synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db <= 1'b0;
    else     db <= sync_p1;
  end
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: synchronized/debounced inputs, output register, edge interrupts.
// Debounce filtering is present only when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int               N_IN            = 12,
  parameter int               N_OUT           = 8,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [N_OUT-1:0] OUT_RESET       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [2:0]        bus_addr,
  input  logic [BUS_W-1:0]  bus_wdata,
  output logic [BUS_W-1:0]  bus_rdata,
  output logic              bus_ready,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  logic [N_IN-1:0]  db, db_q, irq_en, pend, edge_cfg, edge_set, w1c, wr_in;
  logic [BUS_W-1:0] rd_val;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .din (gpio_in[i]),
      .db  (db[i])
    );
  end

  assign wr           = bus_sel && bus_we;
  assign wr_in        = bus_wdata[N_IN-1:0];
  assign w1c          = (wr && bus_addr == GPIO_IRQ_PEND) ? wr_in : '0;
  assign unused_wdata = ^bus_wdata;

  // Edge select bit: 0 picks 0->1 transitions, 1 picks 1->0 transitions.
  assign edge_set = (~edge_cfg & db & ~db_q) | (edge_cfg & ~db & db_q);

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      GPIO_IN:       rd_val[N_IN-1:0]  = db;
      GPIO_OUT:      rd_val[N_OUT-1:0] = gpio_out;
      GPIO_IRQ_EN:   rd_val[N_IN-1:0]  = irq_en;
      GPIO_IRQ_PEND: rd_val[N_IN-1:0]  = pend;
      GPIO_EDGE_CFG: rd_val[N_IN-1:0]  = edge_cfg;
      default:       rd_val            = '0;
    endcase
  end

  // stage p3: bus response, register file, edge/pending/interrupt state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      gpio_out  <= OUT_RESET;
      irq_en    <= '0;
      edge_cfg  <= '0;
      pend      <= '0;
      db_q      <= '0;
      irq       <= 1'b0;
    end else begin
      bus_ready <= bus_sel;
      bus_rdata <= (bus_sel && !bus_we) ? rd_val : '0;
      db_q      <= db;
      // A new edge overrides a same-cycle clear so no event is lost.
      pend      <= (pend & ~w1c) | edge_set;
      irq       <= |(pend & irq_en);
      if (wr) begin
        case (bus_addr)
          GPIO_OUT:      gpio_out <= bus_wdata[N_OUT-1:0];
          GPIO_IRQ_EN:   irq_en   <= wr_in;
          GPIO_EDGE_CFG: edge_cfg <= wr_in;
          GPIO_OUT_SET:  gpio_out <= gpio_out | bus_wdata[N_OUT-1:0];
          GPIO_OUT_CLR:  gpio_out <= gpio_out & ~bus_wdata[N_OUT-1:0];
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised GPIO controller replacing the fixed switch/LED/pushbutton glue in `top`. It samples N_IN board inputs (switches, pushbuttons) through a 2-FF synchronizer and optional per-bit debouncer, and drives N_OUT outputs (LEDs) from a writable register. Per-bit edge detection feeds a maskable interrupt. It sits on the CPU's simple memory-mapped peripheral bus.

## Interface
- `N_IN`, 12, input count (1..32); default is 8 switches + 4 buttons
- `N_OUT`, 8, output count (1..32)
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept an input change (2..65535)
- `OUT_RESET`, 0, reset value of the output register (N_OUT bits)
- `CLK` in 1: single clock; all logic on its rising edge
- `RST` in 1: asynchronous, active-high reset
- `bus_sel` in 1: access request, one cycle per access
- `bus_we` in 1: 1 = write, 0 = read
- `bus_addr` in 3: word register index
- `bus_wdata` in 32: write data
- `bus_rdata` out 32: read data, valid while `bus_ready` = 1
- `bus_ready` out 1: one-cycle completion pulse
- `gpio_in` in N_IN: asynchronous board inputs
- `gpio_out` out N_OUT: registered outputs
- `irq` out 1: level interrupt, registered

## Operation
- Registers (unused upper bits read 0, writes ignored):
  - 0 IN: debounced inputs, RO
  - 1 OUT: output register, RW
  - 2 IRQ_EN: per-input enable, RW
  - 3 IRQ_PEND: per-input pending, write-1-to-clear
  - 4 EDGE_CFG: per-input edge select, 0 = rising, 1 = falling, RW
  - 5 OUT_SET: write-only; OUT |= wdata
  - 6 OUT_CLR: write-only; OUT &= ~wdata
  - 7: reads 0, writes ignored
- Input path per bit: 2-FF synchronizer -> debouncer -> debounced state `db`.
- Debouncer: counter resets to 0 whenever sync == db. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, db takes the sync value and the counter clears. Counter width is $clog2(DEBOUNCE_CYCLES).
- Edge: a 0->1 change of db with EDGE_CFG=0, or a 1->0 change with EDGE_CFG=1, sets PEND on the next cycle. PEND is set regardless of IRQ_EN.
- irq is registered: irq <= |(PEND & IRQ_EN).
- Simultaneous edge-set and W1C on the same bit: set wins, bit stays 1.
- Writes to OUT, OUT_SET and OUT_CLR update gpio_out on the next edge.

## Timing
- Reset values: gpio_out = OUT_RESET; bus_rdata = 0; bus_ready = 0; irq = 0; db, counters, synchronizers, PEND, IRQ_EN, EDGE_CFG = 0.
- Every access, read or write: bus_ready = 1 exactly one cycle after bus_sel. bus_rdata is registered in the same cycle as bus_ready and is 0 when bus_ready = 0.
- Back-to-back accesses: bus_sel is allowed every cycle, and each one gets its own ready pulse.
- Read sees register state from before any write in the same cycle.
- Input-to-IN latency: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- IN-to-PEND: +1 cycle. PEND-to-irq: +1 cycle.
- Glitch shorter than DEBOUNCE_CYCLES cycles (after sync): IN does not change and no edge is recorded.
- RST asserted mid-access or mid-debounce: all state clears immediately. No ready pulse is produced for the interrupted access.

## Configuration
- `GPIO_DEBOUNCE_EN` defined: debouncer present as specified above.
- `GPIO_DEBOUNCE_EN` undefined: db = synchronizer output registered once. Input-to-IN latency is 3 cycles, no counters are instantiated, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package `gpio_pkg`:
  - register index constants (GPIO_IN ... GPIO_OUT_CLR)
  - bus data width 32
  - EDGE_RISE / EDGE_FALL encodings
- One sub-module `gpio_debounce`:
  - single-bit synchronizer + debouncer
  - parameter DEBOUNCE_CYCLES
  - instantiated N_IN times in a generate loop
  - macro gating lives inside it

## Test plan
- Reset release -> gpio_out = OUT_RESET (0x00), irq = 0, read of reg 0..4 returns 0 with bus_ready one cycle after bus_sel.
- Write OUT = 0xA5, then OUT_SET = 0x0A, then OUT_CLR = 0x81 -> gpio_out = 0xA5, then 0xAF, then 0x2E; read OUT returns 0x2E.
- gpio_in[8] 0->1, held steady (DEBOUNCE_CYCLES = 16) -> IN bit 8 = 1 exactly 18 cycles later. A 10-cycle pulse on the same bit -> IN is unchanged and PEND = 0.
- IRQ_EN = 0x100, EDGE_CFG = 0, rising edge on gpio_in[8] -> PEND = 0x100, irq = 1 one cycle later. Write PEND = 0x100 -> irq = 0 two cycles later.
- EDGE_CFG bit 9 = 1, debounced edge on bit 9 coinciding with a W1C of bit 9: rising edge -> PEND bit 9 stays 0; falling edge -> PEND bit 9 = 1 (set wins).
- RST pulse asserted during a pending read and a running debounce count -> bus_ready never pulses, and IN, PEND and gpio_out return to reset values at once.
